bitrev_addr_gen: RTL and testbench

Parametrised read-address generator for the FFT reorder stage. It emits one address per accepted beat, in natural order, bit-reversed order or radix-4 digit-reversed order. Frame length is selected at run time up to 2^ADDR_W points. Outputs use a valid/ready handshake so the block can drive the reorder RAM read port directly, with stalls from the butterfly pipeline honoured.

---
 rtl/bitrev_addr_gen_if.sv | 40 ++++
 rtl/bitrev_addr_gen.sv | 159 +++++++++++++++
 tb/tb_bitrev_addr_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bitrev_addr_gen_if.sv
// Handshake/bus bundle for bitrev_addr_gen. `cont` exists only when
// CONT_MODE_EN is defined (continuous-frame option).
interface bitrev_addr_gen_if #(
  parameter int ADDR_W = 10,
  parameter int LOG_W  = 4
);
  logic              start;
  logic [LOG_W-1:0]  log_len;
  logic [1:0]        mode;
  logic              rdy;
`ifdef CONT_MODE_EN
  logic              cont;
`endif
  logic [ADDR_W-1:0] addr_o;
  logic              valid_o;
  logic              last_o;
  logic              busy;
  logic              done;
  logic              err;

`ifdef CONT_MODE_EN
  modport master (
    output start, log_len, mode, rdy, cont,
    input  addr_o, valid_o, last_o, busy, done, err
  );
  modport slave (
    input  start, log_len, mode, rdy, cont,
    output addr_o, valid_o, last_o, busy, done, err
  );
`else
  modport master (
    output start, log_len, mode, rdy,
    input  addr_o, valid_o, last_o, busy, done, err
  );
  modport slave (
    input  start, log_len, mode, rdy,
    output addr_o, valid_o, last_o, busy, done, err
  );
`endif
endinterface

// File: rtl/bitrev_addr_gen.sv
// FFT reorder read-address generator: natural, bit-reversed or radix-4
// digit-reversed order. Optional back-to-back frames via CONT_MODE_EN.
module bitrev_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LOG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  bitrev_addr_gen_if.slave  bus
);

  localparam int DIGITS = (ADDR_W + 1) / 2;
  localparam int PW     = 2 * DIGITS;
  localparam logic [LOG_W-1:0] MAX_LOG = LOG_W'(ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_NAT = 2'b00, M_BREV = 2'b01, M_DREV = 2'b10, M_ILL = 2'b11} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [LOG_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cfg_ok;
  logic              accept;
  logic              cont_req;
  logic [ADDR_W-1:0] cnt_inc;

  function automatic logic [ADDR_W-1:0] len_mask(input logic [LOG_W-1:0] l);
    return ~({ADDR_W{1'b1}} << l);
  endfunction

  // Reverse across the full padded width, then shift the reversed field down
  // so only the low L bits (or L/2 digits) of the index land in the result.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] idx,
                                                 input logic [LOG_W-1:0]  l,
                                                 input mode_t             m);
    logic [PW-1:0] src, rb, rd, sel;
    int unsigned   sh;
    src = PW'(idx);
    for (int unsigned i = 0; i < PW; i++) rb[i] = src[PW-1-i];
    for (int unsigned k = 0; k < DIGITS; k++) rd[2*k +: 2] = src[2*(DIGITS-1-k) +: 2];
    sh = PW - int'(l);
    case (m)
      M_BREV:  sel = rb >> sh;
      M_DREV:  sel = rd >> sh;
      default: sel = src;
    endcase
    return ADDR_W'(sel) & len_mask(l);
  endfunction

  assign cfg_ok = (bus.log_len != '0) && (bus.log_len <= MAX_LOG) &&
                  (bus.mode != 2'b11) && !((bus.mode == 2'b10) && bus.log_len[0]);
  assign accept  = valid_q && bus.rdy;
  assign cnt_inc = cnt_q + ADDR_W'(1);

`ifdef CONT_MODE_EN
  assign cont_req = bus.cont;
`else
  assign cont_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            len_d   = bus.log_len;
            mode_d  = mode_t'(bus.mode);
            cnt_d   = '0;
            addr_d  = map_addr('0, bus.log_len, mode_t'(bus.mode));
            valid_d = 1'b1;
            last_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last_q && !cont_req) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (last_q) begin
            cnt_d  = '0;
            addr_d = map_addr('0, len_q, mode_q);
            last_d = 1'b0;
          end else begin
            cnt_d  = cnt_inc;
            addr_d = map_addr(cnt_inc, len_q, mode_q);
            last_d = (cnt_inc == len_mask(len_q));
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_NAT;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.addr_o  = addr_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  // A stalled beat must not move or drop.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.rdy) |=> (valid_q && $stable(addr_q) && $stable(last_q)));
  a_last_valid: assert property (@(posedge clk) disable iff (rst) last_q |-> valid_q);

endmodule

// File: tb/tb_bitrev_addr_gen.sv
// Randomized self-checking bench for bitrev_addr_gen against an arithmetic
// reference of the three address orders.
module tb_bitrev_addr_gen;
  localparam int ADDR_W = 10;
  localparam int LOG_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   obs [1024];

  bitrev_addr_gen_if #(.ADDR_W(ADDR_W), .LOG_W(LOG_W)) bus ();
  bitrev_addr_gen #(.ADDR_W(ADDR_W), .LOG_W(LOG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_addr(input int i, input int l, input int m);
    int r = 0;
    if (m == 0) return i % (1 << l);
    if (m == 1) for (int j = 0; j < l; j++) r = r * 2 + ((i >> j) & 1);
    else        for (int k = 0; k < l / 2; k++) r = r * 4 + ((i >> (2 * k)) & 3);
    return r;
  endfunction

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random
  task automatic run_frame(input int l, input int m, input int rdy_mode,
                           input int nfr, input bit mid_start, input int rst_at);
    int n, idx, fr, cyc, budget;
    bit r, ms_done;
    n = 1 << l; idx = 0; fr = 0; cyc = 0; ms_done = 0;
    budget = 8 * n * nfr + 20;
    @(negedge clk);
    bus.start = 1'b1; bus.log_len = LOG_W'(l); bus.mode = 2'(m); bus.rdy = 1'b0;
`ifdef CONT_MODE_EN
    bus.cont = 1'b0;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("busy_start", int'(bus.busy), 1);
    forever begin
      check_eq("valid", int'(bus.valid_o), 1);
      check_eq("addr", int'(bus.addr_o), ref_addr(idx, l, m));
      check_eq("last", int'(bus.last_o), (idx == n - 1) ? 1 : 0);
      check_eq("busy", int'(bus.busy), 1);
      check_eq("err_run", int'(bus.err), 0);
      check_eq("done_run", int'(bus.done), 0);
      if (fr == 0) obs[idx] = int'(bus.addr_o);
      if (idx == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_addr", int'(bus.addr_o), 0);
        check_eq("rst_valid", int'(bus.valid_o), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_last", int'(bus.last_o), 0);
        @(negedge clk);
        rst = 1'b0; bus.rdy = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", int'(bus.valid_o), 0);
        return;
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.rdy = r;
`ifdef CONT_MODE_EN
      bus.cont = (fr < nfr - 1);
`endif
      if (mid_start && !ms_done && idx == n / 2) begin
        bus.start = 1'b1;
        bus.log_len = LOG_W'($urandom_range(0, 15));
        bus.mode = 2'($urandom_range(0, 3));
        ms_done = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (r) begin
        if (idx == n - 1) begin
          if (fr == nfr - 1) break;
          fr++; idx = 0;
        end else begin
          idx++;
        end
      end
      if (cyc > budget) begin
        check_eq("timeout", cyc, budget);
        return;
      end
    end
    bus.rdy = 1'b0; bus.start = 1'b0;
    check_eq("end_valid", int'(bus.valid_o), 0);
    check_eq("end_last", int'(bus.last_o), 0);
    check_eq("end_done", int'(bus.done), 1);
    check_eq("end_busy", int'(bus.busy), 0);
    @(negedge clk);
    check_eq("done_pulse", int'(bus.done), 0);
    check_eq("idle_valid", int'(bus.valid_o), 0);
  endtask

  task automatic illegal_start(input int l, input int m);
    @(negedge clk);
    bus.start = 1'b1; bus.log_len = LOG_W'(l); bus.mode = 2'(m);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("err_pulse", int'(bus.err), 1);
    check_eq("err_busy", int'(bus.busy), 0);
    check_eq("err_valid", int'(bus.valid_o), 0);
    @(negedge clk);
    check_eq("err_clear", int'(bus.err), 0);
    check_eq("err_busy2", int'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bad_l [4];
    int bad_m [4];
    bad_l = '{3, 0, 11, 5};
    bad_m = '{2, 1, 0, 3};
    bus.start = 1'b0; bus.log_len = '0; bus.mode = '0; bus.rdy = 1'b0;
`ifdef CONT_MODE_EN
    bus.cont = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_addr0", int'(bus.addr_o), 0);
    check_eq("rst_valid0", int'(bus.valid_o), 0);
    check_eq("rst_last0", int'(bus.last_o), 0);
    check_eq("rst_busy0", int'(bus.busy), 0);
    check_eq("rst_done0", int'(bus.done), 0);
    check_eq("rst_err0", int'(bus.err), 0);
    rst = 1'b0;

    run_frame(3, 1, 0, 1, 1'b0, -1);
    check_eq("brev3_i1", obs[1], 4);
    check_eq("brev3_i3", obs[3], 6);

    run_frame(4, 2, 0, 1, 1'b0, -1);
    check_eq("drev4_i1", obs[1], 4);
    check_eq("drev4_i6", obs[6], 9);
    check_eq("drev4_i15", obs[15], 15);

    for (int i = 0; i < 4; i++) illegal_start(bad_l[i], bad_m[i]);

    run_frame(3, 0, 1, 1, 1'b0, -1);
    run_frame(5, 1, 2, 1, 1'b1, -1);
    run_frame(6, 2, 2, 1, 1'b1, -1);

    run_frame(4, 0, 0, 1, 1'b0, 3);
    run_frame(4, 1, 2, 1, 1'b0, -1);

    run_frame(10, 1, 0, 1, 1'b0, -1);
    check_eq("brev10_i1", obs[1], 512);
    check_eq("brev10_i1023", obs[1023], 1023);

    for (int t = 0; t < 8; t++) begin
      int m, l;
      m = $urandom_range(0, 2);
      l = (m == 2) ? 2 * $urandom_range(1, 4) : $urandom_range(1, 8);
      run_frame(l, m, 2, 1, $urandom_range(0, 1) == 1, -1);
    end

`ifdef CONT_MODE_EN
    run_frame(2, 1, 0, 2, 1'b0, -1);
    run_frame(4, 2, 2, 3, 1'b0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
